// File: rtl/uart_tx_piso_if.sv
// Load/handshake bundle between a word source and the UART transmit framer.
interface uart_tx_piso_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  load;
    logic [DATA_WIDTH-1:0] parallel_in;
    logic                  ready;
    logic                  busy;
    logic                  done;

    modport master (
        output load,
        output parallel_in,
        input  ready,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  parallel_in,
        output ready,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx_piso.sv
// UART transmit framer: captures one word per handshake and shifts out
// start, LSB-first data, optional parity and 1-2 stop bits on baud_tick.
module uart_tx_piso #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic            tx_clk,
    input  logic            rst,
    input  logic            baud_tick,
    uart_tx_piso_if.slave   bus,
    output logic            serial_out
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] word;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  stop_cnt;
    logic                  ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  parity_c;

    // Parity comes from the captured word, which is never shifted.
    assign parity_c = (^word) ^ (PARITY_ODD != 0);

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            word       <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            serial_out <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                // Ticks are ignored here, so a tick coinciding with accept only arms.
                S_IDLE: begin
                    if (bus.load && ready_q) begin
                        shreg   <= bus.parallel_in;
                        word    <= bus.parallel_in;
                        state   <= S_ARMED;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (baud_tick) begin
                        state      <= S_START;
                        serial_out <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        state      <= S_DATA;
                        serial_out <= shreg[0];
                        shreg      <= shreg >> 1;
                        bit_cnt    <= '0;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            stop_cnt <= 1'b0;
                            if (PARITY_EN != 0) begin
                                state      <= S_PARITY;
                                serial_out <= parity_c;
                            end else begin
                                state      <= S_STOP;
                                serial_out <= 1'b1;
                            end
                        end else begin
                            serial_out <= shreg[0];
                            shreg      <= shreg >> 1;
                            bit_cnt    <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tick) begin
                        state      <= S_STOP;
                        serial_out <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            state   <= S_IDLE;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    serial_out <= 1'b1;
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_piso.sv
// Directed bench for uart_tx_piso: four instances cover no-parity, even,
// odd parity and two stop bits; expected line sequences are hand-written.
module tb_uart_tx_piso;

    logic       tx_clk;
    logic       rst;
    logic       baud_tick;
    logic [3:0] load_v;
    logic [7:0] pdin_v [4];
    logic [3:0] so_v;
    logic [3:0] ready_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    int checks;
    int errors;

    uart_tx_piso_if #(.DATA_WIDTH(8)) if0 ();
    uart_tx_piso_if #(.DATA_WIDTH(8)) if1 ();
    uart_tx_piso_if #(.DATA_WIDTH(8)) if2 ();
    uart_tx_piso_if #(.DATA_WIDTH(8)) if3 ();

    assign if0.load = load_v[0];
    assign if1.load = load_v[1];
    assign if2.load = load_v[2];
    assign if3.load = load_v[3];
    assign if0.parallel_in = pdin_v[0];
    assign if1.parallel_in = pdin_v[1];
    assign if2.parallel_in = pdin_v[2];
    assign if3.parallel_in = pdin_v[3];
    assign ready_v = {if3.ready, if2.ready, if1.ready, if0.ready};
    assign busy_v  = {if3.busy,  if2.busy,  if1.busy,  if0.busy};
    assign done_v  = {if3.done,  if2.done,  if1.done,  if0.done};

    uart_tx_piso #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .tx_clk(tx_clk), .rst(rst), .baud_tick(baud_tick), .bus(if0.slave), .serial_out(so_v[0]));
    uart_tx_piso #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .tx_clk(tx_clk), .rst(rst), .baud_tick(baud_tick), .bus(if1.slave), .serial_out(so_v[1]));
    uart_tx_piso #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .tx_clk(tx_clk), .rst(rst), .baud_tick(baud_tick), .bus(if2.slave), .serial_out(so_v[2]));
    uart_tx_piso #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .tx_clk(tx_clk), .rst(rst), .baud_tick(baud_tick), .bus(if3.slave), .serial_out(so_v[3]));

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with baud_tick = t; returns 1 time unit after the edge.
    task automatic step(input logic t);
        baud_tick = t;
        @(posedge tx_clk);
        #1;
        baud_tick = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic line,
                           input logic rdy, input logic bsy, input logic dn);
        chk({tag, " line"},  16'(so_v[idx]),    16'(line));
        chk({tag, " ready"}, 16'(ready_v[idx]), 16'(rdy));
        chk({tag, " busy"},  16'(busy_v[idx]),  16'(bsy));
        chk({tag, " done"},  16'(done_v[idx]),  16'(dn));
    endtask

    // exp bit k = line after tick k, k=0 being the start-bit tick; the final
    // entry is the line after the tick that ends the last stop bit.
    task automatic send(input int idx, input logic [7:0] data, input logic [15:0] exp,
                        input int n, input int gap, input bit tick_on_load,
                        input bit poke, input int abort_k);
        string tag;
        logic  prev;
        load_v[idx] = 1'b1;
        pdin_v[idx] = data;
        step(tick_on_load);
        load_v[idx] = 1'b0;
        tag = $sformatf("d%0d %02h accept", idx, data);
        chk_all(tag, idx, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < n; k++) begin
            prev = (k == 0) ? 1'b1 : exp[k-1];
            for (int j = 0; j < gap - 1; j++) begin
                if (poke && k == 3 && j == 0) begin
                    load_v[idx] = 1'b1;
                    pdin_v[idx] = 8'hFF;
                end
                step(1'b0);
                load_v[idx] = 1'b0;
                tag = $sformatf("d%0d %02h k%0d gap%0d", idx, data, k, j);
                chk_all(tag, idx, prev, 1'b0, 1'b1, 1'b0);
            end
            step(1'b1);
            tag = $sformatf("d%0d %02h k%0d", idx, data, k);
            chk_all(tag, idx, exp[k], (k == n - 1), (k != n - 1), (k == n - 1));
            if (k == abort_k) begin
                rst = 1'b1;
                load_v[idx] = 1'b1;
                pdin_v[idx] = 8'hEE;
                step(1'b0);
                rst = 1'b0;
                load_v[idx] = 1'b0;
                chk_all($sformatf("d%0d reset edge", idx), idx, 1'b1, 1'b1, 1'b0, 1'b0);
                step(1'b1);
                chk_all($sformatf("d%0d after reset", idx), idx, 1'b1, 1'b1, 1'b0, 1'b0);
                return;
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        baud_tick = 1'b0;
        load_v    = 4'b0001;
        for (int i = 0; i < 4; i++) pdin_v[i] = 8'h55;
        step(1'b1);
        step(1'b0);
        load_v = 4'b0000;
        for (int i = 0; i < 4; i++) chk_all($sformatf("d%0d reset", i), i, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b1);
        chk_all("d0 idle tick", 0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Basic frame, 0xA5: 0, 1,0,1,0,0,1,0,1, stop, idle
        send(0, 8'hA5, {2'b11, 8'hA5, 1'b0}, 11, 4, 1'b0, 1'b0, -1);
        // Even parity on 0xA5 (four ones) is 0; odd is 1; even on 0x07 is 1
        send(1, 8'hA5, {2'b11, 1'b0, 8'hA5, 1'b0}, 12, 3, 1'b0, 1'b0, -1);
        send(2, 8'hA5, {2'b11, 1'b1, 8'hA5, 1'b0}, 12, 3, 1'b0, 1'b0, -1);
        send(1, 8'h07, {2'b11, 1'b1, 8'h07, 1'b0}, 12, 2, 1'b0, 1'b0, -1);
        // Two stop bits on 0x00: done only after the second stop tick
        send(3, 8'h00, {3'b111, 8'h00, 1'b0}, 12, 2, 1'b0, 1'b0, -1);
        // load of 0xFF while busy is ignored; 0x3C goes out intact
        send(0, 8'h3C, {2'b11, 8'h3C, 1'b0}, 11, 3, 1'b0, 1'b1, -1);
        // load in the done cycle is accepted
        send(0, 8'h81, {2'b11, 8'h81, 1'b0}, 11, 2, 1'b0, 1'b0, -1);
        // tick coinciding with load only arms; consecutive ticks afterwards
        send(0, 8'hC3, {2'b11, 8'hC3, 1'b0}, 11, 1, 1'b1, 1'b0, -1);
        // reset while data bit 3 of 0x5A is on the line
        step(1'b0);
        send(0, 8'h5A, {2'b11, 8'h5A, 1'b0}, 11, 3, 1'b0, 1'b0, 4);
        send(0, 8'h12, {2'b11, 8'h12, 1'b0}, 11, 3, 1'b0, 1'b0, -1);
        step(1'b0);
        chk_all("d0 final idle", 0, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_piso.md
# uart_tx_piso

Parallel-in/serial-out framer for the UART transmit path, the transmit-side counterpart of the receiver's serial-to-parallel shifter. It accepts one `DATA_WIDTH`-bit word per handshake and drives a complete frame on `serial_out`: start bit, data LSB-first, optional parity, then one or two stop bits. Bit timing comes from an external one-cycle `baud_tick` enable generated by the baud-rate block. The line idles high.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8, from `uart_params.vh`): data bits per frame.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2; other values are illegal.

Ports:
- `tx_clk  input  1`: the block's only clock; all logic is on its rising edge.
- `rst  input  1`: synchronous, active-high reset.
- `baud_tick  input  1`: one-`tx_clk` pulse marking each bit-period boundary.
- `load  input  1`: request to send `parallel_in`.
- `parallel_in  input  DATA_WIDTH`: word to transmit; sampled only on accept.
- `ready  output  1`: high when a `load` will be accepted.
- `busy  output  1`: high while a frame is armed or in flight.
- `done  output  1`: one-cycle pulse when the last stop bit completes.
- `serial_out  output  1`: registered UART line.

## Operation
- FSM states: IDLE, ARMED, START, DATA, PARITY, STOP.
- IDLE: `ready`=1, `busy`=0, `serial_out`=1.
  - Accept = `load` & `ready`, sampled at the clock edge.
  - On accept: `parallel_in` is captured into the shift register and the FSM goes to ARMED.
  - `baud_tick` in the accept cycle is ignored.
- ARMED: line stays 1. The next `baud_tick` moves to START, and `serial_out` becomes 0.
  - Every frame therefore begins on a tick boundary, and every bit is a full period.
- START: the next tick moves to DATA and `serial_out` drives shift-register bit 0.
- DATA: each tick shifts right by one and increments the bit counter.
  - The counter is `$clog2(DATA_WIDTH)` bits wide and counts 0..DATA_WIDTH-1.
  - The tick that ends bit DATA_WIDTH-1 moves to PARITY if `PARITY_EN`=1, otherwise to STOP.
- PARITY: drives the XOR of the captured word, inverted when `PARITY_ODD`=1. Parity is computed from the captured copy, not the shifted register.
  - The next tick moves to STOP.
- STOP: drives 1 for `STOP_BITS` ticks. The tick ending the final stop bit returns the FSM to IDLE and asserts `done` for exactly one cycle.
- `busy` equals (state != IDLE). `ready` equals (state == IDLE) and is registered, not combinational from `load`.
- `load` while `ready`=0 is ignored; nothing is queued. `parallel_in` changing mid-frame has no effect.
- `load` asserted during `rst` is ignored.

## Timing
- Reset values, effective on the first edge with `rst`=1 and applied regardless of state (mid-frame included):
  - `serial_out`=1, `ready`=1, `busy`=0, `done`=0.
  - State IDLE; shift register and counters cleared.
- A truncated frame is abandoned; the line returns high on the reset edge.
- Accept edge to `ready`=0: same edge, visible the next cycle.
- Accept to first start-bit edge: the next `baud_tick` after accept, whatever its distance.
- Frame length from the start-bit tick to `done`: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) ticks.
- `done` and `ready`=1 appear in the same cycle, immediately after the final stop-bit tick.
- Back-to-back operation:
  - A `load` in the `done` cycle is accepted.
  - The line then stays high until the next tick, so at least one full idle bit period separates frames.
- `baud_tick` asserted on consecutive cycles is legal; each pulse advances one bit.
- `serial_out` changes only on tick edges or reset and never glitches between them.

## Test plan
- **Basic frame.** DATA_WIDTH=8, no parity, 1 stop, tick every 4 cycles, load 0xA5.
  - Line per tick: 0, 1,0,1,0,0,1,0,1, 1.
  - `done` after 10 ticks; `busy` high throughout.
- **Parity.** PARITY_EN=1.
  - Even parity, 0xA5 → parity bit 0. Odd parity, 0xA5 → 1.
  - Even parity, 0x07 → 1.
  - Frame is 11 ticks.
- **Two stop bits.** STOP_BITS=2, load 0x00.
  - Line per tick: 0, eight 0s, 1, 1.
  - `done` on the 11th tick; no `done` after the first stop tick.
- **Handshake.**
  - `load` with 0xFF while busy sending 0x3C → ignored; 0x3C is sent intact.
  - `load` in the `done` cycle with 0x81 → accepted; start bit on the next tick.
- **Tick/load coincidence.** `load` and `baud_tick` in the same cycle → state ARMED, line stays 1; the start bit begins on the following tick.
- **Reset mid-frame.** Assert `rst` during data bit 3 of 0x5A.
  - Next edge: `serial_out`=1, `ready`=1, `busy`=0, no `done`.
  - A new load of 0x12 then transmits correctly.
